// File: rtl/rsa_pkg.sv
// Shared types and defaults for the modular exponentiation datapath.
package rsa_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [3:0] {
        IDLE,
        REDUCE,
        WAIT_RED,
        CHECK,
        MUL,
        WAIT_MUL,
        SQR,
        WAIT_SQR,
        FINISH
    } modexp_state_t;

endpackage

// File: rtl/modmult.sv
// Iterative modular multiplier: result = (a * b) mod n, go/done handshake.
// The full product is formed on go, then reduced one bit per cycle by
// restoring remainder, so any a, b < 2^WIDTH and any n >= 1 are handled.
module modmult
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] result_o,
    output logic             done_o
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(PW + 1);

    logic             busy_q,   busy_d;
    logic [PW-1:0]    prod_q,   prod_d;
    logic [WIDTH-1:0] rem_q,    rem_d;
    logic [WIDTH-1:0] n_q,      n_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q,   done_d;

    logic [WIDTH:0]   rem_shift_c;
    logic [WIDTH-1:0] rem_red_c;

    // One restoring-remainder step: shift in next product bit, subtract n if it fits.
    always_comb begin
        rem_shift_c = {rem_q, prod_q[PW-1]};
        if (rem_shift_c >= {1'b0, n_q}) begin
            rem_red_c = WIDTH'(rem_shift_c - {1'b0, n_q});
        end else begin
            rem_red_c = rem_shift_c[WIDTH-1:0];
        end
    end

    // Next-state: load on go when idle, otherwise step the reduction.
    always_comb begin
        busy_d   = busy_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (busy_q) begin
            prod_d = prod_q << 1;
            rem_d  = rem_red_c;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                result_d = rem_red_c;
            end
        end else if (go_i) begin
            prod_d = PW'(a_i) * PW'(b_i);
            rem_d  = '0;
            n_d    = n_i;
            cnt_d  = CW'(PW);
            busy_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            prod_q   <= '0;
            rem_q    <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = done_q;

endmodule

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply controller driving one modmult instance.
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    modexp_state_t    state_q,    state_d;
    logic [WIDTH-1:0] base_q,     base_d;
    logic [WIDTH-1:0] n_q,        n_d;
    logic [WIDTH-1:0] e_q,        e_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [WIDTH-1:0] b_q,        b_d;
    logic             mul_last_q, mul_last_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             done_q,     done_d;
    logic             busy_q,     busy_d;

    logic             mm_go_c;
    logic [WIDTH-1:0] mm_a_c;
    logic [WIDTH-1:0] mm_b_c;
    logic [WIDTH-1:0] mm_result;
    logic             mm_done;

    // Request strobe and operand select; operands hold through the matching WAIT state.
    always_comb begin
        mm_go_c = ((state_q == REDUCE) && (n_q != '0)) ||
                  (state_q == MUL) || (state_q == SQR);
        case (state_q)
            REDUCE, WAIT_RED: begin
                mm_a_c = base_q;
                mm_b_c = WIDTH'(1);
            end
            MUL, WAIT_MUL: begin
                mm_a_c = acc_q;
                mm_b_c = b_q;
            end
            default: begin
                mm_a_c = b_q;
                mm_b_c = b_q;
            end
        endcase
    end

    modmult #(
        .WIDTH (WIDTH)
    ) u_modmult (
        .clk      (clk),
        .rst_n    (rst),
        .go_i     (mm_go_c),
        .a_i      (mm_a_c),
        .b_i      (mm_b_c),
        .n_i      (n_q),
        .result_o (mm_result),
        .done_o   (mm_done)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        e_d        = e_q;
        acc_d      = acc_q;
        b_d        = b_q;
        mul_last_d = mul_last_q;
        result_d   = result_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    base_d     = base;
                    n_d        = modulus;
                    e_d        = exponent;
                    // n of 0 or 1 forces a zero result even with no multiplies
                    acc_d      = (modulus >= WIDTH'(2)) ? WIDTH'(1) : '0;
                    b_d        = '0;
                    mul_last_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = REDUCE;
                end
            end
            REDUCE: begin
                state_d = (n_q == '0) ? FINISH : WAIT_RED;
            end
            WAIT_RED: begin
                if (mm_done) begin
                    b_d     = mm_result;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (e_q == '0) begin
                    state_d = FINISH;
                end else if (e_q[0]) begin
                    state_d = MUL;
                end else begin
                    state_d = SQR;
                end
            end
            MUL: begin
                state_d = WAIT_MUL;
            end
            WAIT_MUL: begin
                if (mm_done) begin
                    acc_d      = mm_result;
                    e_d        = e_q >> 1;
                    mul_last_d = 1'b1;
                    // no square once the exponent is exhausted
                    state_d    = ((e_q >> 1) == '0) ? CHECK : SQR;
                end
            end
            SQR: begin
                state_d = WAIT_SQR;
            end
            WAIT_SQR: begin
                if (mm_done) begin
                    b_d = mm_result;
                    if (!mul_last_q) begin
                        e_d = e_q >> 1;
                    end
                    mul_last_d = 1'b0;
                    state_d    = CHECK;
                end
            end
            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All controller registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            n_q        <= '0;
            e_q        <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            mul_last_q <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            e_q        <= e_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            mul_last_q <= mul_last_d;
            result_q   <= result_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl against a plain-arithmetic modexp model.
module tb_modexp_ctrl;
    import rsa_pkg::*;

    localparam int unsigned W      = 16;
    localparam int          BUDGET = 3000;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [W-1:0] base;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic [W-1:0] result;
    logic         done;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    modexp_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: base^exponent mod modulus by textbook square-and-multiply.
    function automatic logic [W-1:0] model(input longint unsigned b, input longint unsigned e,
                                           input longint unsigned n);
        longint unsigned r, x;
        if (n == 0) return '0;
        r = 1 % n;
        x = b % n;
        while (e != 0) begin
            if (e[0]) r = (r * x) % n;
            x = (x * x) % n;
            e = e >> 1;
        end
        return W'(r);
    endfunction

    task automatic start_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n);
        @(negedge clk);
        base = b; exponent = e; modulus = n; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Waits at negedges for done; cyc = clock edges elapsed after the go-accepting edge.
    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; go = 1'b0; base = '0; exponent = '0; modulus = '0;
        #12;
        n_cmp++;
        if ({result, done, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got result=%0d done=%0b busy=%0b, want all 0", result, done, busy);
        end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got done=%0b busy=%0b, want 0 0", done, busy);
        end
    endtask

    task automatic test_basic();
        int cyc; bit to;
        start_op(16'd13, 16'd11, 16'd17);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy_start: got %0b want 1", busy);
        end
        base = 16'd999; exponent = 16'd3; modulus = 16'd5;
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd4) begin
            n_err++;
            $display("FAIL basic_13_11_17: got %0d (timeout=%0b) want 4", result, to);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy_in_done: got %0b want 1", busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 16'd4) begin
            n_err++;
            $display("FAIL basic_after_done: got done=%0b busy=%0b result=%0d want 0 0 4", done, busy, result);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit to;
        start_op(16'd4, 16'd13, 16'd497);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd445) begin
            n_err++;
            $display("FAIL b2b_first: got %0d (timeout=%0b) want 445", result, to);
        end
        // go raised during the done cycle is accepted on the next edge
        base = 16'd2; exponent = 16'd10; modulus = 16'd1000; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || result !== 16'd445) begin
            n_err++;
            $display("FAIL b2b_second_accept: got busy=%0b result=%0d want 1 445", busy, result);
        end
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd24) begin
            n_err++;
            $display("FAIL b2b_second: got %0d (timeout=%0b) want 24", result, to);
        end
    endtask

    task automatic test_exp_zero();
        int cyc; bit to;
        start_op(16'd5, 16'd0, 16'd17);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd1) begin
            n_err++;
            $display("FAIL exp0_mod17: got %0d (timeout=%0b) want 1", result, to);
        end
        start_op(16'd5, 16'd0, 16'd1);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd0) begin
            n_err++;
            $display("FAIL exp0_mod1: got %0d (timeout=%0b) want 0", result, to);
        end
    endtask

    task automatic test_mod_zero();
        int cyc; bit to;
        start_op(16'd20, 16'd3, 16'd17);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd10) begin
            n_err++;
            $display("FAIL reduce_20_3_17: got %0d (timeout=%0b) want 10", result, to);
        end
        start_op(16'd7, 16'd5, 16'd0);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd0) begin
            n_err++;
            $display("FAIL mod0_result: got %0d (timeout=%0b) want 0", result, to);
        end
        n_cmp++;
        if (cyc != 2) begin
            n_err++;
            $display("FAIL mod0_latency: got %0d cycles want 2", cyc);
        end
    endtask

    task automatic test_go_while_busy();
        int cyc; bit to; int extra;
        start_op(16'd13, 16'd11, 16'd17);
        repeat (5) @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        base = 16'($urandom); exponent = 16'($urandom); modulus = 16'($urandom);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd4) begin
            n_err++;
            $display("FAIL go_busy_result: got %0d (timeout=%0b) want 4", result, to);
        end
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL go_busy_no_rerun: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit to; int waited; int seen;
        start_op(16'd13, 16'd11, 16'd17);
        waited = 0;
        while (dut.state_q != WAIT_MUL && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (waited >= BUDGET) begin
            n_err++;
            $display("FAIL rstmid_reach_wait_mul: got timeout after %0d cycles want WAIT_MUL", waited);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({result, done, busy} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got result=%0d done=%0b busy=%0b want all 0", result, done, busy);
        end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL rstmid_no_done: got %0d active cycles want 0", seen);
        end
        start_op(16'd13, 16'd11, 16'd17);
        wait_done(cyc, to);
        n_cmp++;
        if (to || result !== 16'd4) begin
            n_err++;
            $display("FAIL rstmid_rerun: got %0d (timeout=%0b) want 4", result, to);
        end
    endtask

    task automatic test_random();
        int cyc; bit to;
        logic [W-1:0] b, e, n, exp_r;
        for (int k = 0; k < 20; k++) begin
            b = W'($urandom);
            e = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            n = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            exp_r = model(64'(b), 64'(e), 64'(n));
            start_op(b, e, n);
            base = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
            wait_done(cyc, to);
            n_cmp++;
            if (to || result !== exp_r) begin
                n_err++;
                $display("FAIL random_%0d: %0d^%0d mod %0d got %0d (timeout=%0b) want %0d",
                         k, b, e, n, result, to, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_exp_zero();
        test_mod_zero();
        test_go_while_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 go  input  1  start request, sampled only in IDLE.
REQ-005 base  input  WIDTH  base operand, captured on accepted go.
REQ-006 exponent  input  WIDTH  exponent, captured on accepted go.
REQ-007 modulus  input  WIDTH  modulus n, captured on accepted go.
REQ-008 result  output  WIDTH  base^exponent mod modulus, held stable from done until next accepted go.
REQ-009 done  output  1  one-cycle pulse, result valid in same cycle.
REQ-010 busy  output  1  high from cycle after accepted go through done cycle inclusive.

Function
REQ-011 Block shall be the initiator of the modmult go/done protocol: one-cycle go pulse with a, b, n stable until done; accept modmult result only on its done pulse.
REQ-012 Algorithm: right-to-left square-and-multiply; acc=1, b=base mod n, e=exponent.
REQ-013 States: IDLE, REDUCE, WAIT_RED, CHECK, MUL, WAIT_MUL, SQR, WAIT_SQR, FINISH.
REQ-014 IDLE: go=1 at rising edge captures operands and moves to REDUCE; go=0 stays IDLE.
REQ-015 REDUCE: issue modmult(base, 1, n); WAIT_RED stores product into b, then CHECK.
REQ-016 CHECK: e==0 -> FINISH; e[0]==1 -> MUL; else SQR.
REQ-017 MUL: issue modmult(acc, b, n); WAIT_MUL stores acc; e>>1; then CHECK if new e==0, else SQR.
REQ-018 SQR: issue modmult(b, b, n); WAIT_SQR stores b; if previous step was not MUL, e>>1; then CHECK.
REQ-019 Squaring shall be skipped once remaining exponent is zero (early termination).
REQ-020 FINISH: result<=acc, done=1 for exactly one cycle, busy deasserts next cycle, return to IDLE.
REQ-021 exponent==0: result=1 if n>=2, 0 if n==1; no multiplications issued beyond REDUCE.
REQ-022 modulus==0: skip all modmult requests, result=0, done asserted 2 cycles after go accepted.
REQ-023 go while busy shall be ignored; operands changing while busy shall not affect result.
REQ-024 Modmult go to sub-module shall never be asserted while a prior request awaits done.
REQ-025 Latency = 2 + sum of modmult latencies (1 reduce + popcount(e) mults + (msb_index(e)) squares) + 1.

Reset
REQ-026 On rst=0, immediately: state IDLE, result=0, done=0, busy=0, modmult go=0, internal acc/b/e cleared.
REQ-027 Reset mid-operation shall abort the run with no done pulse; sub-module modmult reset by same rst.
REQ-028 First go after reset release shall be accepted normally.

Structure
REQ-029 State enum (modexp_state_t) and default WIDTH constant shall live in shared package rsa_pkg.
REQ-030 Exactly one sub-module instance: modmult #(WIDTH), driven only by this controller.
REQ-031 All registers in one always_ff with async active-low reset; next-state in separate always_comb.

Verification
REQ-032 base=13, exponent=11, modulus=17, go pulse -> one done pulse, result=4, busy low after.
REQ-033 base=4, exponent=13, modulus=497 -> result=445; then base=2, exponent=10, modulus=1000 -> result=24 back-to-back.
REQ-034 exponent=0, modulus=17 -> result=1; exponent=0, modulus=1 -> result=0; modulus=0 -> result=0 in 2 cycles.
REQ-035 base=20 (>n), exponent=3, modulus=17 -> result=10 (reduction path exercised).
REQ-036 go re-pulsed mid-run with different operands -> ignored, original result delivered.
REQ-037 rst=0 during WAIT_MUL -> outputs zero same cycle, no done; next go with 13,11,17 -> result=4.
